// File: rtl/kitchen_order_scheduler.sv
// Two-kiosk order intake with round-robin arbitration, a small order FIFO
// and a cook FSM that times each item before presenting the finished order.
module kitchen_order_scheduler #(
    parameter int DEPTH         = 4,
    parameter int PREP_BURGER   = 8,
    parameter int PREP_FRIES    = 4,
    parameter int PREP_COLA     = 1,
    parameter int PREP_ICECREAM = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        k0_req,
    input  logic [15:0] k0_qty,
    input  logic [7:0]  k0_total,
    output logic        k0_ack,
    input  logic        k1_req,
    input  logic [15:0] k1_qty,
    input  logic [7:0]  k1_total,
    output logic        k1_ack,
    output logic        serve_valid,
    input  logic        serve_ready,
    output logic [7:0]  serve_id,
    output logic [7:0]  serve_total,
    output logic [1:0]  cook_item,
    output logic        busy,
    output logic [3:0]  fifo_count
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD, COOK, SERVE} state_t;

    typedef struct packed {
        logic [15:0] qty;
        logic [7:0]  total;
        logic [7:0]  id;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [3:0]      count;
    logic            prio1;
    logic [7:0]      next_id;

    state_t          state;
    logic [1:0]      item;
    logic [3:0]      remaining;
    logic [7:0]      timer;
    logic [15:0]     qty_r;

    logic            elig0, elig1, room, grant0, grant1, push, pop, adv;
    logic [15:0]     sel_qty;
    logic [7:0]      sel_total;
    logic [1:0]      item_nx;
    entry_t          head;

    function automatic logic [7:0] prep_m1(input logic [1:0] i);
        logic [7:0] r;
        unique case (i)
            2'd0: r = 8'(PREP_BURGER - 1);
            2'd1: r = 8'(PREP_FRIES - 1);
            2'd2: r = 8'(PREP_COLA - 1);
            default: r = 8'(PREP_ICECREAM - 1);
        endcase
        return r;
    endfunction

    function automatic logic [3:0] qty_of(input logic [15:0] q,
                                          input logic [1:0] i);
        logic [15:0] s;
        s = q >> {i, 2'b00};
        return s[3:0];
    endfunction

    // A kiosk whose ack is showing this cycle is not re-considered.
    assign elig0     = k0_req & ~k0_ack;
    assign elig1     = k1_req & ~k1_ack;
    assign room      = count < 4'(DEPTH);
    assign grant0    = room & elig0 & (~elig1 | ~prio1);
    assign grant1    = room & elig1 & ~grant0;
    assign sel_qty   = grant0 ? k0_qty : k1_qty;
    assign sel_total = grant0 ? k0_total : k1_total;
    assign push      = (grant0 | grant1) & (sel_qty != 16'd0);
    assign pop       = (state == LOAD);
    assign head      = mem[rd_ptr];
    assign item_nx   = item + 2'd1;
    assign adv       = (remaining == 4'd0) ||
                       (timer == 8'd0 && remaining == 4'd1);
    assign fifo_count = count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            k0_ack  <= 1'b0;
            k1_ack  <= 1'b0;
            prio1   <= 1'b0;
            next_id <= 8'd0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= 4'd0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            k0_ack <= grant0;
            k1_ack <= grant1;
            if (grant0) prio1 <= 1'b1;
            if (grant1) prio1 <= 1'b0;
            if (push) begin
                mem[wr_ptr] <= '{qty: sel_qty, total: sel_total, id: next_id};
                wr_ptr      <= wr_ptr + 1'b1;
                next_id     <= next_id + 8'd1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop) count <= count + 4'd1;
            else if (pop && !push) count <= count - 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            item        <= 2'd0;
            remaining   <= 4'd0;
            timer       <= 8'd0;
            qty_r       <= 16'd0;
            serve_valid <= 1'b0;
            serve_id    <= 8'd0;
            serve_total <= 8'd0;
            cook_item   <= 2'd0;
            busy        <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (count != 4'd0) begin
                    state <= LOAD;
                    busy  <= 1'b1;
                end
                LOAD: begin
                    qty_r       <= head.qty;
                    serve_id    <= head.id;
                    serve_total <= head.total;
                    item        <= 2'd0;
                    cook_item   <= 2'd0;
                    remaining   <= qty_of(head.qty, 2'd0);
                    timer       <= prep_m1(2'd0);
                    state       <= COOK;
                end
                COOK: begin
                    if (adv) begin
                        if (item == 2'd3) begin
                            state       <= SERVE;
                            serve_valid <= 1'b1;
                        end else begin
                            item      <= item_nx;
                            cook_item <= item_nx;
                            remaining <= qty_of(qty_r, item_nx);
                            timer     <= prep_m1(item_nx);
                        end
                    end else if (timer == 8'd0) begin
                        remaining <= remaining - 4'd1;
                        timer     <= prep_m1(item);
                    end else begin
                        timer <= timer - 8'd1;
                    end
                end
                SERVE: if (serve_ready) begin
                    state       <= IDLE;
                    serve_valid <= 1'b0;
                    busy        <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_kitchen_order_scheduler.sv
// Directed bench for kitchen_order_scheduler: vector table of single orders
// plus hand-written arbitration, back-pressure and reset sequences.
module tb_kitchen_order_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        k0_req = 1'b0, k1_req = 1'b0;
    logic [15:0] k0_qty = '0, k1_qty = '0;
    logic [7:0]  k0_total = '0, k1_total = '0;
    logic        k0_ack, k1_ack;
    logic        serve_valid;
    logic        serve_ready = 1'b1;
    logic [7:0]  serve_id, serve_total;
    logic [1:0]  cook_item;
    logic        busy;
    logic [3:0]  fifo_count;

    int errors = 0;
    int checks = 0;

    kitchen_order_scheduler dut (
        .clk(clk), .reset(reset),
        .k0_req(k0_req), .k0_qty(k0_qty), .k0_total(k0_total), .k0_ack(k0_ack),
        .k1_req(k1_req), .k1_qty(k1_qty), .k1_total(k1_total), .k1_ack(k1_ack),
        .serve_valid(serve_valid), .serve_ready(serve_ready),
        .serve_id(serve_id), .serve_total(serve_total),
        .cook_item(cook_item), .busy(busy), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] qty;
        logic [7:0]  total;
        int          lat;
        logic [7:0]  id;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [31:0] outs();
        return {14'd0, k0_ack, k1_ack, serve_valid, serve_id, serve_total,
                cook_item, busy, fifo_count};
    endfunction

    task automatic do_reset();
        k0_req = 1'b0;
        k1_req = 1'b0;
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        step(1);
    endtask

    task automatic wait_serve(output int n);
        n = 0;
        while (!serve_valid && n < 300) begin
            step(1);
            n++;
        end
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        k0_qty = v.qty;
        k0_total = v.total;
        k0_req = 1'b1;
        step(1);
        chk("vec_ack", k0_ack, 1);
        k0_req = 1'b0;
        wait_serve(n);
        chk("vec_latency", n, v.lat);
        chk("vec_id", serve_id, v.id);
        chk("vec_total", serve_total, v.total);
        chk("vec_last_item", cook_item, 3);
        step(1);
        chk("vec_serve_drop", serve_valid, 0);
        step(1);
    endtask

    initial begin
        int n, nacks, ord, kid, extra, got;
        logic stable;
        logic [7:0] ids [2];
        logic [7:0] tots [2];

        vecs[0] = '{16'h0201, 8'd130, 14, 8'd0};
        vecs[1] = '{16'h0030, 8'd25, 17, 8'd1};
        vecs[2] = '{16'h5000, 8'd60, 15, 8'd2};
        vecs[3] = '{16'h1111, 8'd255, 17, 8'd3};
        vecs[4] = '{16'h000F, 8'd7, 125, 8'd4};
        vecs[5] = '{16'hFF00, 8'd199, 49, 8'd5};

        step(1);
        chk("in_reset_outputs", outs(), 0);
        reset = 1'b0;
        step(1);
        chk("post_reset_outputs", outs(), 0);

        // Zero-quantity order: acked, nothing queued, no id consumed.
        k0_qty = 16'h0000;
        k0_total = 8'd5;
        k0_req = 1'b1;
        step(1);
        chk("zero_ack", k0_ack, 1);
        chk("zero_count", fifo_count, 0);
        k0_req = 1'b0;
        step(1);
        chk("zero_ack_once", k0_ack, 0);
        step(3);
        chk("zero_busy", busy, 0);
        chk("zero_count_later", fifo_count, 0);

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Simultaneous requests on an empty FIFO.
        do_reset();
        k0_qty = 16'h0100; k0_total = 8'd40;
        k1_qty = 16'h0100; k1_total = 8'd41;
        k0_req = 1'b1;
        k1_req = 1'b1;
        step(1);
        chk("sim_k0_first", {k0_ack, k1_ack}, 2'b10);
        k0_req = 1'b0;
        step(1);
        chk("sim_k1_second", {k0_ack, k1_ack}, 2'b01);
        k1_req = 1'b0;
        got = 0;
        ids[0] = '0; ids[1] = '0; tots[0] = '0; tots[1] = '0;
        for (int c = 0; c < 100; c++) begin
            step(1);
            if (serve_valid && got < 2) begin
                ids[got] = serve_id;
                tots[got] = serve_total;
                got++;
            end
        end
        chk("sim_serves", got, 2);
        chk("sim_id0", ids[0], 0);
        chk("sim_tot0", tots[0], 40);
        chk("sim_id1", ids[1], 1);
        chk("sim_tot1", tots[1], 41);

        // Both kiosks hold req; serve stalled so the FIFO fills.
        do_reset();
        serve_ready = 1'b0;
        k0_qty = 16'h0001; k0_total = 8'd1;
        k1_qty = 16'h0001; k1_total = 8'd2;
        k0_req = 1'b1;
        k1_req = 1'b1;
        nacks = 0;
        ord = 0;
        for (int c = 0; c < 8; c++) begin
            step(1);
            if (k0_ack) begin nacks++; ord = ord * 2; end
            if (k1_ack) begin nacks++; ord = ord * 2 + 1; end
        end
        chk("fill_acks", nacks, 5);
        chk("fill_order", ord, 10);
        chk("fill_count", fifo_count, 4);
        extra = 0;
        n = 0;
        while (!serve_valid && n < 50) begin
            step(1);
            n++;
            if (k0_ack || k1_ack) extra++;
        end
        chk("fill_serve_seen", serve_valid, 1);
        for (int c = 0; c < 5; c++) begin
            step(1);
            if (k0_ack || k1_ack) extra++;
        end
        chk("full_no_ack", extra, 0);
        chk("full_count", fifo_count, 4);
        serve_ready = 1'b1;
        step(1);
        serve_ready = 1'b0;
        nacks = 0;
        kid = -1;
        for (int c = 0; c < 6; c++) begin
            step(1);
            if (k0_ack) begin nacks++; kid = 0; end
            if (k1_ack) begin nacks++; kid = 1; end
        end
        chk("pop_one_ack", nacks, 1);
        chk("pop_ack_kiosk", kid, 1);
        chk("pop_refill_count", fifo_count, 4);
        k0_req = 1'b0;
        k1_req = 1'b0;

        // Serve back-pressure with an enqueue during SERVE.
        do_reset();
        serve_ready = 1'b0;
        k0_qty = 16'h0100; k0_total = 8'd11;
        k0_req = 1'b1;
        step(1);
        k0_req = 1'b0;
        wait_serve(n);
        chk("hold_serve_up", serve_valid, 1);
        k1_qty = 16'h0010; k1_total = 8'd22;
        k1_req = 1'b1;
        step(1);
        chk("hold_k1_ack", k1_ack, 1);
        k1_req = 1'b0;
        chk("hold_count", fifo_count, 1);
        stable = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step(1);
            if (!serve_valid || serve_id != 8'd0 || serve_total != 8'd11)
                stable = 1'b0;
        end
        chk("hold_stable", stable, 1);
        serve_ready = 1'b1;
        step(1);
        chk("hold_release_valid", serve_valid, 0);
        chk("hold_release_idle", busy, 0);
        step(1);
        chk("hold_next_load", busy, 1);
        wait_serve(n);
        chk("hold_next_id", serve_id, 1);
        chk("hold_next_total", serve_total, 22);
        step(2);

        // Reset in the middle of cooking with two orders queued.
        do_reset();
        k0_qty = 16'h000F; k0_total = 8'd9;
        k1_qty = 16'h0100; k1_total = 8'd10;
        k0_req = 1'b1;
        step(1);
        k0_req = 1'b0;
        k1_req = 1'b1;
        step(1);
        k1_req = 1'b0;
        k0_req = 1'b1;
        step(1);
        k0_req = 1'b0;
        step(2);
        chk("mid_busy", busy, 1);
        chk("mid_count", fifo_count, 2);
        reset = 1'b1;
        #1;
        chk("mid_reset_outputs", outs(), 0);
        step(2);
        reset = 1'b0;
        extra = 0;
        for (int c = 0; c < 60; c++) begin
            step(1);
            if (serve_valid || busy || fifo_count != 4'd0) extra++;
        end
        chk("mid_no_activity", extra, 0);
        k1_qty = 16'h0100; k1_total = 8'd77;
        k1_req = 1'b1;
        step(1);
        k1_req = 1'b0;
        wait_serve(n);
        chk("mid_after_latency", n, 6);
        chk("mid_after_id", serve_id, 0);
        chk("mid_after_total", serve_total, 77);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/kitchen_order_scheduler.md
Name: kitchen_order_scheduler

Overview:
- Shares one kitchen between two ordering kiosks.
- Each kiosk hands over a confirmed order: per-item quantities plus the total price.
- A round-robin arbiter accepts orders into a small FIFO. A cook FSM pops orders one at a time, times the preparation of every item, then presents the finished order on a serve handshake.
- Sits downstream of the kiosk order-entry blocks and upstream of the pickup display.

Parameters:
- DEPTH, 4: FIFO entries (power of two, 2..8).
- PREP_BURGER, 8: cycles to prepare one burger.
- PREP_FRIES, 4: cycles per fries.
- PREP_COLA, 1: cycles per cola.
- PREP_ICECREAM, 2: cycles per ice cream.
- Constraint on all PREP_*: 1..255.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- k0_req  in  1  kiosk 0 order pending; held with data until k0_ack
- k0_qty  in  16  kiosk 0 quantities: [3:0] burger, [7:4] fries, [11:8] cola, [15:12] ice cream
- k0_total  in  8  kiosk 0 order price
- k0_ack  out  1  one-cycle pulse: kiosk 0 order taken
- k1_req, k1_qty, k1_total, k1_ack  same as kiosk 0, for kiosk 1
- serve_valid  out  1  finished order presented
- serve_ready  in  1  pickup side accepts finished order
- serve_id  out  8  order number of the presented order
- serve_total  out  8  price of the presented order
- cook_item  out  2  item currently being cooked (0 burger .. 3 ice cream)
- busy  out  1  cook FSM not IDLE
- fifo_count  out  4  entries queued (0..DEPTH)

Behaviour:

Reset values:
- All outputs 0. FIFO empty. FSM IDLE. Order-id counter 0. Round-robin pointer favours kiosk 0.
- Reset mid-operation discards queued and in-progress orders; no serve is emitted.

Arbitration:
- A kiosk is eligible when its req=1 and its ack is 0 this cycle.
- A grant is given on a clock edge only if fifo_count<DEPTH before that edge. Full blocks the push even if a pop occurs in the same cycle; there is no bypass.
- When both kiosks are eligible, the one not granted last wins.
- The pointer updates only on a grant. Only one grant per cycle.
- On a grant, kN_ack=1 for exactly the next cycle. The kiosk must drop req in the cycle it sees ack; ack never repeats for the same req assertion.

Enqueue:
- An order with all quantities 0 is acked but not enqueued, and consumes no id.
- Otherwise the entry {qty, total, id} is written, with id = counter.
- The counter then increments, 8-bit, wrapping 255->0.

Cook FSM:
- IDLE: if FIFO non-empty -> LOAD.
- LOAD: pop the head; latch qty, id and total; item=0; load remaining=qty[item] and timer=PREP[item]-1 -> COOK.
- COOK, remaining=0: advance to the next item in 1 cycle.
- COOK, remaining>0: the timer counts down.
  - When the timer reaches 0, remaining decrements and the timer reloads.
  - When the last unit finishes, advance directly.
  - A nonzero item therefore costs qty*PREP cycles; a zero item costs 1 cycle.
- After item 3 completes -> SERVE.
- SERVE: serve_valid=1 with serve_id and serve_total stable. Hold until serve_ready=1 is sampled, then -> IDLE with serve_valid=0 the next cycle.
- Output behaviour: cook_item reflects item in COOK and holds its last value elsewhere. busy=1 in LOAD, COOK and SERVE.

Latency:
- A req is granted at edge E0; the FIFO and ack update after E0.
- IDLE->LOAD at E1, LOAD->COOK at E2.
- The cook spans C cycles; serve_valid rises after edge E(2+C).

Simultaneity:
- Push and pop in the same cycle: fifo_count unchanged.
- A new order may be enqueued while the FSM is in SERVE.

Test Plan:
- Reset, then k0 req burger=1, cola=2, total 130 -> k0_ack pulses 1 cycle; C=8+1+2+1=12; serve_valid rises 14 cycles after the grant edge with serve_id=0, serve_total=130.
- k0 and k1 req in the same cycle, FIFO empty -> k0 acked first, k1 the next cycle; ids 0 and 1; served in order 0 then 1.
- Both kiosks hold req continuously with stub orders -> grants alternate k0,k1,k0,k1; the FIFO fills to 4; further reqs get no ack until the FSM pops (count 4->3 -> one ack).
- Order with all quantities 0 -> ack pulses, fifo_count stays 0, busy stays 0; the next real order gets id 0.
- serve_ready held 0 for 20 cycles during SERVE -> serve_valid, serve_id and serve_total stay stable; FIFO accepts new orders meanwhile; on serve_ready=1 the FSM returns to IDLE and starts the next order.
- Assert reset mid-COOK with 2 orders queued -> all outputs 0 immediately; no serve_valid after release; the next order gets id 0.
